id_scoreboard_ctrl: RTL and testbench

- Parametrised successor of the decode-stage hazard controller.
- Replaces fixed three-stage rd comparison with a per-register pending-write scoreboard:
  - configurable source-operand count;
  - configurable writeback port count;
  - multiple outstanding writes per register.
- Sits between IF and EX.
- Owns the ID-stage valid/ready handshake, the held destination of the ID-slot instruction, flush and scoreboard-clear.

---
 rtl/id_scoreboard_ctrl.sv | 159 +++++++++++++++
 tb/tb_id_scoreboard_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage hazard controller with a per-register pending-write scoreboard.
// Owns the ID valid/ready handshake, the held destination, flush and scoreboard clear.
module id_scoreboard_ctrl #(
    parameter int NUM_SRC       = 3,
    parameter int NUM_WB        = 2,
    parameter int GRP_W         = 2,
    parameter int IDX_W         = 5,
    parameter int CNT_W         = 2,
    parameter int GROUP_INVALID = 0,
    parameter int GROUP_ZERO    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IF_valid,
    output logic                     ready,
    output logic                     valid,
    input  logic                     EX_ready,
    input  logic [NUM_SRC*GRP_W-1:0] src_group,
    input  logic [NUM_SRC*IDX_W-1:0] src_index,
    input  logic [GRP_W-1:0]         rd_group,
    input  logic [IDX_W-1:0]         rd_index,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*GRP_W-1:0]  wb_group,
    input  logic [NUM_WB*IDX_W-1:0]  wb_index,
    input  logic                     flush,
    input  logic                     sb_clear,
    output logic [GRP_W-1:0]         held_rd_group,
    output logic [IDX_W-1:0]         held_rd_index,
    output logic                     stall_raw,
    output logic                     sb_err
);

    localparam int REG_W = GRP_W + IDX_W;
    localparam int NREG  = 1 << REG_W;
    localparam int SUM_W = CNT_W + $clog2(NUM_WB + 1) + 1;
    localparam logic [SUM_W-1:0] CMAX   = SUM_W'((1 << CNT_W) - 1);
    localparam logic [GRP_W-1:0] G_INV  = GRP_W'(GROUP_INVALID);
    localparam logic [GRP_W-1:0] G_ZERO = GRP_W'(GROUP_ZERO);

    function automatic logic is_trk(input logic [REG_W-1:0] r);
        logic [GRP_W-1:0] g;
        logic [IDX_W-1:0] i;
        g = r[REG_W-1 -: GRP_W];
        i = r[IDX_W-1:0];
        return (g != G_INV) && !((g == G_ZERO) && (i == '0));
    endfunction

    logic             valid_q, valid_d;
    logic [REG_W-1:0] held_q, held_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic [REG_W-1:0] src_a [NUM_SRC];
    logic [REG_W-1:0] wb_a  [NUM_WB];
    logic [REG_W-1:0] rd_a;
    logic             src_hazard;
    logic             rd_sat;
    logic             dispatch;
    logic             accept;
    logic             held_trk;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_a[k] = {src_group[k*GRP_W +: GRP_W], src_index[k*IDX_W +: IDX_W]};
        end
        for (int j = 0; j < NUM_WB; j++) begin
            wb_a[j] = {wb_group[j*GRP_W +: GRP_W], wb_index[j*IDX_W +: IDX_W]};
        end
    end

    assign rd_a     = {rd_group, rd_index};
    assign held_trk = is_trk(held_q);

    // Held-slot match covers the write that has not yet been counted.
    always_comb begin
        src_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (is_trk(src_a[k]) &&
                ((cnt_q[src_a[k]] != '0) || (valid_q && (held_q == src_a[k])))) begin
                src_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        rd_sat = 1'b0;
        if (is_trk(rd_a)) begin
            rd_sat = (SUM_W'(cnt_q[rd_a]) + SUM_W'(valid_q && (held_q == rd_a))) >= CMAX;
        end
    end

    assign dispatch  = valid_q & EX_ready & ~flush;
    assign ready     = (~valid_q | EX_ready) & ~src_hazard & ~rd_sat & ~flush & ~sb_clear;
    assign accept    = ready & IF_valid;
    assign stall_raw = src_hazard & IF_valid;

    always_comb begin
        if (flush || sb_clear) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (dispatch) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        held_d = accept ? rd_a : held_q;
    end

    // Increment and all releases of an entry are summed; an over-release clamps to zero.
    always_comb begin
        logic [SUM_W-1:0] cur;
        logic [SUM_W-1:0] dec;
        err_d = err_q;
        cur   = '0;
        dec   = '0;
        for (int e = 0; e < NREG; e++) begin
            cur = SUM_W'(cnt_q[e]) +
                  SUM_W'(dispatch && held_trk && (held_q == REG_W'(e)));
            dec = '0;
            for (int j = 0; j < NUM_WB; j++) begin
                dec = dec + SUM_W'(wb_valid[j] && is_trk(wb_a[j]) &&
                                   (wb_a[j] == REG_W'(e)));
            end
            if (dec > cur) begin
                cnt_d[e] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[e] = CNT_W'(cur - dec);
            end
            if (sb_clear) begin
                cnt_d[e] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            held_q  <= {G_INV, {IDX_W{1'b0}}};
            err_q   <= 1'b0;
            for (int e = 0; e < NREG; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid         = valid_q;
    assign held_rd_group = held_q[REG_W-1 -: GRP_W];
    assign held_rd_index = held_q[IDX_W-1:0];
    assign sb_err        = err_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Bench for id_scoreboard_ctrl: scoreboard model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_scoreboard_ctrl;

    localparam int NS   = 3;
    localparam int NW   = 2;
    localparam int GW   = 2;
    localparam int IW   = 5;
    localparam int NREG = 128;
    localparam int CMAX = 3;
    localparam int R    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          IF_valid;
    logic          ready;
    logic          valid;
    logic          EX_ready;
    logic [NS*GW-1:0] src_group;
    logic [NS*IW-1:0] src_index;
    logic [GW-1:0] rd_group;
    logic [IW-1:0] rd_index;
    logic [NW-1:0] wb_valid;
    logic [NW*GW-1:0] wb_group;
    logic [NW*IW-1:0] wb_index;
    logic          flush;
    logic          sb_clear;
    logic [GW-1:0] held_rd_group;
    logic [IW-1:0] held_rd_index;
    logic          stall_raw;
    logic          sb_err;

    always #5 clk = ~clk;

    id_scoreboard_ctrl dut (
        .clk(clk), .rst(rst), .IF_valid(IF_valid), .ready(ready),
        .valid(valid), .EX_ready(EX_ready),
        .src_group(src_group), .src_index(src_index),
        .rd_group(rd_group), .rd_index(rd_index),
        .wb_valid(wb_valid), .wb_group(wb_group), .wb_index(wb_index),
        .flush(flush), .sb_clear(sb_clear),
        .held_rd_group(held_rd_group), .held_rd_index(held_rd_index),
        .stall_raw(stall_raw), .sb_err(sb_err)
    );

    int checks = 0;
    int errors = 0;
    bit on = 1'b0;

    int cnt_m [NREG];
    bit valid_m;
    bit err_m;
    int hg_m;
    int hi_m;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit trk(input int g, input int i);
        return (g != 0) && !((g == 1) && (i == 0));
    endfunction

    function automatic int dcnt(input int g, input int i);
        return int'(dut.cnt_q[g*32 + i]);
    endfunction

    function automatic bit m_haz();
        for (int k = 0; k < NS; k++) begin
            int g;
            int i;
            g = int'(src_group[k*GW +: GW]);
            i = int'(src_index[k*IW +: IW]);
            if (trk(g, i) && (cnt_m[g*32 + i] > 0 || (valid_m && hg_m == g && hi_m == i)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_sat();
        int g;
        int i;
        int pend;
        g = int'(rd_group);
        i = int'(rd_index);
        if (!trk(g, i)) return 1'b0;
        pend = cnt_m[g*32 + i] + ((valid_m && hg_m == g && hi_m == i) ? 1 : 0);
        return pend >= CMAX;
    endfunction

    function automatic bit m_ready();
        return (!valid_m || EX_ready) && !m_haz() && !m_sat() && !flush && !sb_clear;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (cnt_m[e]) cnt_m[e] = 0;
            valid_m = 1'b0;
            err_m   = 1'b0;
            hg_m    = 0;
            hi_m    = 0;
        end else if (on) begin
            bit disp;
            bit acc;
            int tmp [NREG];
            disp = valid_m && EX_ready && !flush;
            acc  = m_ready() && IF_valid;
            tmp  = cnt_m;
            if (disp && trk(hg_m, hi_m)) tmp[hg_m*32 + hi_m]++;
            for (int j = 0; j < NW; j++) begin
                int g;
                int i;
                g = int'(wb_group[j*GW +: GW]);
                i = int'(wb_index[j*IW +: IW]);
                if (wb_valid[j] && trk(g, i)) begin
                    if (tmp[g*32 + i] == 0) err_m = 1'b1;
                    else tmp[g*32 + i]--;
                end
            end
            if (sb_clear) foreach (tmp[e]) tmp[e] = 0;
            cnt_m = tmp;
            if (flush || sb_clear) valid_m = 1'b0;
            else if (acc) valid_m = 1'b1;
            else if (disp) valid_m = 1'b0;
            if (acc) begin
                hg_m = int'(rd_group);
                hi_m = int'(rd_index);
            end
        end
    end

    always @(negedge clk) begin
        if (on) begin
            chk("ready", int'(ready), int'(m_ready()));
            chk("stall_raw", int'(stall_raw), int'(m_haz() && IF_valid));
            chk("valid", int'(valid), int'(valid_m));
            chk("sb_err", int'(sb_err), int'(err_m));
            if (valid_m) begin
                chk("held_g", int'(held_rd_group), hg_m);
                chk("held_i", int'(held_rd_index), hi_m);
            end
            for (int e = 0; e < NREG; e++) begin
                if (int'(dut.cnt_q[e]) != cnt_m[e])
                    chk($sformatf("cnt[%0d]", e), int'(dut.cnt_q[e]), cnt_m[e]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        IF_valid  = 1'b0;
        EX_ready  = 1'b1;
        src_group = '0;
        src_index = '0;
        rd_group  = '0;
        rd_index  = '0;
        wb_valid  = '0;
        wb_group  = '0;
        wb_index  = '0;
        flush     = 1'b0;
        sb_clear  = 1'b0;
    endtask

    task automatic instr(input int rg, input int ri, input int sg, input int si);
        src_group = '0;
        src_index = '0;
        src_group[GW-1:0] = GW'(sg);
        src_index[IW-1:0] = IW'(si);
        rd_group = GW'(rg);
        rd_index = IW'(ri);
    endtask

    task automatic wb(input int j, input int g, input int i);
        wb_valid[j] = 1'b1;
        wb_group[j*GW +: GW] = GW'(g);
        wb_index[j*IW +: IW] = IW'(i);
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_held_g", int'(held_rd_group), 0);
        chk("rst_err", int'(sb_err), 0);
        rst = 1'b0;
        on  = 1'b1;

        // RAW through held slot, then through counter until release
        instr(R, 5, 0, 0); IF_valid = 1'b1;
        #2 chk("a_ready0", int'(ready), 1);
        tick();
        instr(0, 0, R, 5);
        #2 chk("a_ready1", int'(ready), 0);
        chk("a_stall1", int'(stall_raw), 1);
        tick();
        wb(0, R, 5);
        #2 chk("a_cnt5", dcnt(R, 5), 1);
        chk("a_ready2", int'(ready), 0);
        chk("a_stall2", int'(stall_raw), 1);
        tick();
        wb_valid = '0;
        #2 chk("a_ready3", int'(ready), 1);
        chk("a_cnt5b", dcnt(R, 5), 0);
        tick();
        IF_valid = 1'b0;
        tick();

        // held rd blocks a reader, x0 does not
        EX_ready = 1'b0;
        instr(R, 7, 0, 0); IF_valid = 1'b1;
        tick();
        instr(0, 0, R, 7);
        #2 chk("b_ready", int'(ready), 0);
        chk("b_stall", int'(stall_raw), 1);
        instr(0, 0, R, 0);
        #1 chk("b_stall_x0", int'(stall_raw), 0);
        EX_ready = 1'b1;
        #1 chk("b_ready_x0", int'(ready), 1);
        tick();
        IF_valid = 1'b0;
        tick();
        #2 chk("b_cnt7", dcnt(R, 7), 1);
        wb(1, R, 7);
        tick();
        wb_valid = '0;
        #2 chk("b_cnt7b", dcnt(R, 7), 0);

        // counter saturation on rd
        instr(R, 3, 0, 0); IF_valid = 1'b1;
        tick(); tick(); tick();
        #2 chk("c_sat_ready", int'(ready), 0);
        chk("c_sat_stall", int'(stall_raw), 0);
        tick();
        #2 chk("c_cnt3", dcnt(R, 3), 3);
        chk("c_ready", int'(ready), 0);
        wb(0, R, 3);
        tick();
        wb_valid = '0;
        #2 chk("c_ready_rel", int'(ready), 1);
        tick();
        IF_valid = 1'b0;
        tick();
        #2 chk("c_cnt3b", dcnt(R, 3), 3);

        // dispatch and two releases of one register in one cycle; underflow
        instr(R, 9, 0, 0); IF_valid = 1'b1;
        tick(); tick(); tick();
        IF_valid = 1'b0;
        wb(0, R, 9); wb(1, R, 9);
        tick();
        wb_valid = '0;
        #2 chk("d_cnt9", dcnt(R, 9), 1);
        chk("d_valid", int'(valid), 0);
        wb(0, R, 9);
        tick();
        wb_valid = '0;
        #2 chk("d_cnt9z", dcnt(R, 9), 0);
        chk("d_err0", int'(sb_err), 0);
        wb(0, R, 9);
        tick();
        wb_valid = '0;
        #2 chk("d_err1", int'(sb_err), 1);
        chk("d_cnt9u", dcnt(R, 9), 0);

        // flush kills the slot without counting
        EX_ready = 1'b0;
        instr(R, 4, 0, 0); IF_valid = 1'b1;
        tick();
        IF_valid = 1'b0; EX_ready = 1'b1; flush = 1'b1;
        #2 chk("e_ready", int'(ready), 0);
        tick();
        flush = 1'b0;
        #2 chk("e_valid", int'(valid), 0);
        chk("e_cnt4", dcnt(R, 4), 0);

        // scoreboard clear releases a pending dependency
        instr(0, 0, R, 3); IF_valid = 1'b1;
        #2 chk("f_stall", int'(stall_raw), 1);
        sb_clear = 1'b1;
        tick();
        sb_clear = 1'b0;
        #2 chk("f_cnt3", dcnt(R, 3), 0);
        chk("f_ready", int'(ready), 1);
        chk("f_err", int'(sb_err), 1);
        tick();
        #2 chk("f_valid", int'(valid), 1);
        IF_valid = 1'b0;
        tick();

        // asynchronous reset with work outstanding
        instr(R, 5, 0, 0); IF_valid = 1'b1;
        tick(); tick();
        IF_valid = 1'b0; EX_ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("g_valid", int'(valid), 0);
        chk("g_err", int'(sb_err), 0);
        chk("g_cnt5", dcnt(R, 5), 0);
        tick();
        rst = 1'b0;
        instr(0, 0, R, 5); IF_valid = 1'b1; EX_ready = 1'b1;
        #2 chk("g_ready", int'(ready), 1);
        tick();
        #2 chk("g_valid1", int'(valid), 1);
        IF_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
